issue_queue: RTL and testbench

- Out-of-order issue queue directly downstream of the scoreboard: holds dispatched instructions together with the per-source wakeup state (match, shift_r, delay) the scoreboard produces at dispatch.
- Performs tag-broadcast wakeup with latency shift-registers and oldest-first 2-wide select.
- Drives the inst_issued/bc_dst broadcast that the scoreboard and other queues consume.

---
 rtl/issue_queue.sv | 275 +++++++++++++++++++++++++++
 tb/tb_issue_queue.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_queue.sv
// rtl/issue_queue.sv - out-of-order issue queue with tag-broadcast wakeup and oldest-first 2-wide select
module issue_queue #(
    parameter int ENTRIES     = 8,
    parameter int PHY_REG_SEL = 6,
    parameter int MAX_LATENCY = 4,
    parameter int PAYLOAD_W   = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         dis_valid_1,
    input  logic [PAYLOAD_W-1:0]         dis_payload_1,
    input  logic [PHY_REG_SEL-1:0]       dis_dst_1,
    input  logic                         dis_wr_reg_1,
    input  logic [PHY_REG_SEL-1:0]       dis_src1_1,
    input  logic [PHY_REG_SEL-1:0]       dis_src2_1,
    input  logic                         dis_match1_1,
    input  logic                         dis_match2_1,
    input  logic [MAX_LATENCY-1:0]       dis_shift_r1_1,
    input  logic [MAX_LATENCY-1:0]       dis_shift_r2_1,
    input  logic [MAX_LATENCY-1:0]       dis_delay1_1,
    input  logic [MAX_LATENCY-1:0]       dis_delay2_1,
    input  logic                         dis_valid_2,
    input  logic [PAYLOAD_W-1:0]         dis_payload_2,
    input  logic [PHY_REG_SEL-1:0]       dis_dst_2,
    input  logic                         dis_wr_reg_2,
    input  logic [PHY_REG_SEL-1:0]       dis_src1_2,
    input  logic [PHY_REG_SEL-1:0]       dis_src2_2,
    input  logic                         dis_match1_2,
    input  logic                         dis_match2_2,
    input  logic [MAX_LATENCY-1:0]       dis_shift_r1_2,
    input  logic [MAX_LATENCY-1:0]       dis_shift_r2_2,
    input  logic [MAX_LATENCY-1:0]       dis_delay1_2,
    input  logic [MAX_LATENCY-1:0]       dis_delay2_2,
    output logic                         dis_ready,
    input  logic                         ext_bc_valid_1,
    input  logic [PHY_REG_SEL-1:0]       ext_bc_dst_1,
    input  logic                         ext_bc_valid_2,
    input  logic [PHY_REG_SEL-1:0]       ext_bc_dst_2,
    output logic                         inst_issued_1,
    output logic [PHY_REG_SEL-1:0]       bc_dst_1,
    output logic                         iss_valid_1,
    output logic [PAYLOAD_W-1:0]         iss_payload_1,
    output logic                         inst_issued_2,
    output logic [PHY_REG_SEL-1:0]       bc_dst_2,
    output logic                         iss_valid_2,
    output logic [PAYLOAD_W-1:0]         iss_payload_2,
    output logic [$clog2(ENTRIES):0]     free_cnt
);
    localparam int IW = $clog2(ENTRIES);
    localparam int CW = $clog2(ENTRIES) + 1;
    localparam int T  = PHY_REG_SEL;
    localparam int L  = MAX_LATENCY;

    // Entry storage; older_q[i][j]=1 means entry i is older than entry j
    logic [ENTRIES-1:0]   valid_q;
    logic [ENTRIES-1:0]   wr_reg_q;
    logic [PAYLOAD_W-1:0] payload_q [ENTRIES];
    logic [T-1:0]         dst_q     [ENTRIES];
    logic [T-1:0]         tag_q     [ENTRIES][2];
    logic                 match_q   [ENTRIES][2];
    logic [L-1:0]         shr_q     [ENTRIES][2];
    logic [L-1:0]         dly_q     [ENTRIES][2];
    logic [ENTRIES-1:0]   older_q   [ENTRIES];

    // Dispatch slots gathered into arrays, index 0 = slot 1
    logic [PAYLOAD_W-1:0] d_payload [2];
    logic [T-1:0]         d_dst     [2];
    logic                 d_wr      [2];
    logic [T-1:0]         d_tag     [2][2];
    logic                 d_match   [2][2];
    logic [L-1:0]         d_shr     [2][2];
    logic [L-1:0]         d_dly     [2][2];

    logic                 ent_m_n   [ENTRIES][2];
    logic [L-1:0]         ent_sh_n  [ENTRIES][2];
    logic                 dis_m_n   [2][2];
    logic [L-1:0]         dis_sh_n  [2][2];

    logic [3:0]           bc_v;
    logic [3:0][T-1:0]    bc_t;
    logic [ENTRIES-1:0]   cand;
    logic [ENTRIES-1:0]   grant1;
    logic [ENTRIES-1:0]   grant2;
    logic [CW-1:0]        older_cnt [ENTRIES];
    logic                 wr1;
    logic                 wr2;
    logic [IW-1:0]        idx [2];
    logic                 we  [2];
    logic                 found1;
    logic                 found2;

    function automatic logic tag_hit(input logic [3:0] v, input logic [3:0][T-1:0] t,
                                     input logic [T-1:0] tag);
        logic h;
        h = 1'b0;
        for (int b = 0; b < 4; b++) begin
            if (v[b] && t[b] == tag) h = 1'b1;
        end
        return h;
    endfunction

    // Returns {match, shift_r} after one wakeup step
    function automatic logic [L:0] wake(input logic hit, input logic m, input logic [L-1:0] sh,
                                        input logic [L-1:0] dly);
        if (hit)
            return {1'b1, dly};
        else if (m && !sh[0])
            return {1'b1, sh[L-1], sh[L-1:1]};
        else
            return {m, sh};
    endfunction

    assign bc_v = {ext_bc_valid_2, ext_bc_valid_1, inst_issued_2, inst_issued_1};
    assign bc_t = {ext_bc_dst_2, ext_bc_dst_1, bc_dst_2, bc_dst_1};

    // Collect dispatch inputs into slot/source arrays
    always_comb begin
        d_payload[0] = dis_payload_1;   d_payload[1] = dis_payload_2;
        d_dst[0]     = dis_dst_1;       d_dst[1]     = dis_dst_2;
        d_wr[0]      = dis_wr_reg_1;    d_wr[1]      = dis_wr_reg_2;
        d_tag[0][0]  = dis_src1_1;      d_tag[0][1]  = dis_src2_1;
        d_tag[1][0]  = dis_src1_2;      d_tag[1][1]  = dis_src2_2;
        d_match[0][0] = dis_match1_1;   d_match[0][1] = dis_match2_1;
        d_match[1][0] = dis_match1_2;   d_match[1][1] = dis_match2_2;
        d_shr[0][0]  = dis_shift_r1_1;  d_shr[0][1]  = dis_shift_r2_1;
        d_shr[1][0]  = dis_shift_r1_2;  d_shr[1][1]  = dis_shift_r2_2;
        d_dly[0][0]  = dis_delay1_1;    d_dly[0][1]  = dis_delay2_1;
        d_dly[1][0]  = dis_delay1_2;    d_dly[1][1]  = dis_delay2_2;
    end

    // Wakeup step for resident sources and for sources arriving this cycle (same-cycle bypass)
    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            for (int s = 0; s < 2; s++) begin
                {ent_m_n[i][s], ent_sh_n[i][s]} = wake(tag_hit(bc_v, bc_t, tag_q[i][s]),
                                                       match_q[i][s], shr_q[i][s], dly_q[i][s]);
            end
        end
        for (int k = 0; k < 2; k++) begin
            for (int s = 0; s < 2; s++) begin
                {dis_m_n[k][s], dis_sh_n[k][s]} = wake(tag_hit(bc_v, bc_t, d_tag[k][s]),
                                                       d_match[k][s], d_shr[k][s], d_dly[k][s]);
            end
        end
    end

    // Free count and dispatch readiness from registered occupancy only
    always_comb begin
        free_cnt = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            free_cnt = free_cnt + {{(CW-1){1'b0}}, ~valid_q[i]};
        end
        dis_ready = (free_cnt >= CW'(2));
        we[0] = dis_valid_1 && dis_ready && !flush;
        we[1] = dis_valid_2 && dis_ready && !flush;
    end

    // Slot 1 takes the lowest free index, slot 2 the lowest one slot 1 did not take
    always_comb begin
        idx[0] = '0;
        idx[1] = '0;
        found1 = 1'b0;
        found2 = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (!valid_q[i] && !found1) begin
                idx[0] = IW'(i);
                found1 = 1'b1;
            end
        end
        for (int i = 0; i < ENTRIES; i++) begin
            if (!valid_q[i] && !found2 && !(we[0] && idx[0] == IW'(i))) begin
                idx[1] = IW'(i);
                found2 = 1'b1;
            end
        end
    end

    // Oldest-first select: rank each candidate by how many older candidates exist
    always_comb begin
        cand   = '0;
        grant1 = '0;
        grant2 = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            cand[i] = valid_q[i] && shr_q[i][0][0] && shr_q[i][1][0] && !flush;
        end
        for (int i = 0; i < ENTRIES; i++) begin
            older_cnt[i] = '0;
            for (int j = 0; j < ENTRIES; j++) begin
                older_cnt[i] = older_cnt[i] + {{(CW-1){1'b0}}, cand[j] && older_q[j][i]};
            end
            if (cand[i] && older_cnt[i] == CW'(0)) grant1[i] = 1'b1;
            if (cand[i] && older_cnt[i] == CW'(1)) grant2[i] = 1'b1;
        end
    end

    // Issue port muxes; idle ports drive zeros
    always_comb begin
        iss_valid_1   = |grant1;
        iss_valid_2   = |grant2;
        iss_payload_1 = '0;
        iss_payload_2 = '0;
        bc_dst_1      = '0;
        bc_dst_2      = '0;
        wr1           = 1'b0;
        wr2           = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (grant1[i]) begin
                iss_payload_1 = payload_q[i];
                bc_dst_1      = dst_q[i];
                wr1           = wr_reg_q[i];
            end
            if (grant2[i]) begin
                iss_payload_2 = payload_q[i];
                bc_dst_2      = dst_q[i];
                wr2           = wr_reg_q[i];
            end
        end
    end

    assign inst_issued_1 = iss_valid_1 && wr1;
    assign inst_issued_2 = iss_valid_2 && wr2;

    // Entry state: wakeup, issue retire, dispatch write with age update, flush
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q  <= '0;
            wr_reg_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                payload_q[i] <= '0;
                dst_q[i]     <= '0;
                older_q[i]   <= '0;
                for (int s = 0; s < 2; s++) begin
                    tag_q[i][s]   <= '0;
                    match_q[i][s] <= 1'b0;
                    shr_q[i][s]   <= '0;
                    dly_q[i][s]   <= '0;
                end
            end
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                for (int s = 0; s < 2; s++) begin
                    match_q[i][s] <= ent_m_n[i][s];
                    shr_q[i][s]   <= ent_sh_n[i][s];
                end
            end
            valid_q <= valid_q & ~(grant1 | grant2);
            // Slot 2 is written after slot 1 so it ends up younger than slot 1
            for (int k = 0; k < 2; k++) begin
                if (we[k]) begin
                    valid_q[idx[k]]   <= 1'b1;
                    payload_q[idx[k]] <= d_payload[k];
                    dst_q[idx[k]]     <= d_dst[k];
                    wr_reg_q[idx[k]]  <= d_wr[k];
                    older_q[idx[k]]   <= '0;
                    for (int s = 0; s < 2; s++) begin
                        tag_q[idx[k]][s]   <= d_tag[k][s];
                        match_q[idx[k]][s] <= dis_m_n[k][s];
                        shr_q[idx[k]][s]   <= dis_sh_n[k][s];
                        dly_q[idx[k]][s]   <= d_dly[k][s];
                    end
                    for (int j = 0; j < ENTRIES; j++) begin
                        if (IW'(j) != idx[k]) older_q[j][idx[k]] <= 1'b1;
                    end
                end
            end
            if (flush) valid_q <= '0;
        end
    end

    // Dispatch must not be presented while fewer than two entries are free
    assert property (@(posedge clk) disable iff (!reset)
                     (dis_valid_1 || dis_valid_2) |-> dis_ready);

endmodule

// File: tb/tb_issue_queue.sv
// tb/tb_issue_queue.sv - directed self-checking bench for issue_queue
module tb_issue_queue;
    logic        clk;
    logic        reset;
    logic        flush;
    logic        dis_valid_1, dis_valid_2;
    logic [31:0] dis_payload_1, dis_payload_2;
    logic [5:0]  dis_dst_1, dis_dst_2;
    logic        dis_wr_reg_1, dis_wr_reg_2;
    logic [5:0]  dis_src1_1, dis_src2_1, dis_src1_2, dis_src2_2;
    logic        dis_match1_1, dis_match2_1, dis_match1_2, dis_match2_2;
    logic [3:0]  dis_shift_r1_1, dis_shift_r2_1, dis_shift_r1_2, dis_shift_r2_2;
    logic [3:0]  dis_delay1_1, dis_delay2_1, dis_delay1_2, dis_delay2_2;
    logic        dis_ready;
    logic        ext_bc_valid_1, ext_bc_valid_2;
    logic [5:0]  ext_bc_dst_1, ext_bc_dst_2;
    logic        inst_issued_1, inst_issued_2;
    logic [5:0]  bc_dst_1, bc_dst_2;
    logic        iss_valid_1, iss_valid_2;
    logic [31:0] iss_payload_1, iss_payload_2;
    logic [3:0]  free_cnt;

    int checks = 0;
    int errors = 0;

    issue_queue #(.ENTRIES(8), .PHY_REG_SEL(6), .MAX_LATENCY(4), .PAYLOAD_W(32)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .dis_valid_1(dis_valid_1), .dis_payload_1(dis_payload_1), .dis_dst_1(dis_dst_1),
        .dis_wr_reg_1(dis_wr_reg_1), .dis_src1_1(dis_src1_1), .dis_src2_1(dis_src2_1),
        .dis_match1_1(dis_match1_1), .dis_match2_1(dis_match2_1),
        .dis_shift_r1_1(dis_shift_r1_1), .dis_shift_r2_1(dis_shift_r2_1),
        .dis_delay1_1(dis_delay1_1), .dis_delay2_1(dis_delay2_1),
        .dis_valid_2(dis_valid_2), .dis_payload_2(dis_payload_2), .dis_dst_2(dis_dst_2),
        .dis_wr_reg_2(dis_wr_reg_2), .dis_src1_2(dis_src1_2), .dis_src2_2(dis_src2_2),
        .dis_match1_2(dis_match1_2), .dis_match2_2(dis_match2_2),
        .dis_shift_r1_2(dis_shift_r1_2), .dis_shift_r2_2(dis_shift_r2_2),
        .dis_delay1_2(dis_delay1_2), .dis_delay2_2(dis_delay2_2),
        .dis_ready(dis_ready),
        .ext_bc_valid_1(ext_bc_valid_1), .ext_bc_dst_1(ext_bc_dst_1),
        .ext_bc_valid_2(ext_bc_valid_2), .ext_bc_dst_2(ext_bc_dst_2),
        .inst_issued_1(inst_issued_1), .bc_dst_1(bc_dst_1),
        .iss_valid_1(iss_valid_1), .iss_payload_1(iss_payload_1),
        .inst_issued_2(inst_issued_2), .bc_dst_2(bc_dst_2),
        .iss_valid_2(iss_valid_2), .iss_payload_2(iss_payload_2),
        .free_cnt(free_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        flush = 1'b0;
        dis_valid_1 = 0; dis_payload_1 = 0; dis_dst_1 = 0; dis_wr_reg_1 = 0;
        dis_src1_1 = 0; dis_src2_1 = 0; dis_match1_1 = 0; dis_match2_1 = 0;
        dis_shift_r1_1 = 0; dis_shift_r2_1 = 0; dis_delay1_1 = 0; dis_delay2_1 = 0;
        dis_valid_2 = 0; dis_payload_2 = 0; dis_dst_2 = 0; dis_wr_reg_2 = 0;
        dis_src1_2 = 0; dis_src2_2 = 0; dis_match1_2 = 0; dis_match2_2 = 0;
        dis_shift_r1_2 = 0; dis_shift_r2_2 = 0; dis_delay1_2 = 0; dis_delay2_2 = 0;
        ext_bc_valid_1 = 0; ext_bc_dst_1 = 0; ext_bc_valid_2 = 0; ext_bc_dst_2 = 0;
    endtask

    task automatic slot(input int k, input logic [31:0] pay, input logic [5:0] dst, input logic wr,
                        input logic [5:0] t1, input logic m1, input logic [3:0] s1, input logic [3:0] d1,
                        input logic [5:0] t2, input logic m2, input logic [3:0] s2, input logic [3:0] d2);
        if (k == 1) begin
            dis_valid_1 = 1; dis_payload_1 = pay; dis_dst_1 = dst; dis_wr_reg_1 = wr;
            dis_src1_1 = t1; dis_match1_1 = m1; dis_shift_r1_1 = s1; dis_delay1_1 = d1;
            dis_src2_1 = t2; dis_match2_1 = m2; dis_shift_r2_1 = s2; dis_delay2_1 = d2;
        end else begin
            dis_valid_2 = 1; dis_payload_2 = pay; dis_dst_2 = dst; dis_wr_reg_2 = wr;
            dis_src1_2 = t1; dis_match1_2 = m1; dis_shift_r1_2 = s1; dis_delay1_2 = d1;
            dis_src2_2 = t2; dis_match2_2 = m2; dis_shift_r2_2 = s2; dis_delay2_2 = d2;
        end
    endtask

    task automatic slot_rdy(input int k, input logic [31:0] pay, input logic [5:0] dst, input logic wr);
        slot(k, pay, dst, wr, 6'd0, 1'b1, 4'b0001, 4'b1111, 6'd0, 1'b1, 4'b0001, 4'b1111);
    endtask

    task automatic slot_wait(input int k, input logic [31:0] pay, input logic [5:0] dst, input logic wr,
                             input int s, input logic [5:0] tag, input logic [3:0] dly);
        if (s == 1)
            slot(k, pay, dst, wr, tag, 1'b0, 4'b0000, dly, 6'd0, 1'b1, 4'b0001, 4'b1111);
        else
            slot(k, pay, dst, wr, 6'd0, 1'b1, 4'b0001, 4'b1111, tag, 1'b0, 4'b0000, dly);
    endtask

    initial begin
        clr();
        reset = 1'b0;
        // Reset held with a ready dispatch pending
        slot_rdy(1, 32'hA1, 6'd10, 1'b1);
        #2;
        chk("rst_iss_valid_1", iss_valid_1, 0);
        chk("rst_iss_valid_2", iss_valid_2, 0);
        chk("rst_inst_issued_1", inst_issued_1, 0);
        chk("rst_iss_payload_1", iss_payload_1, 0);
        chk("rst_free_cnt", free_cnt, 8);
        chk("rst_dis_ready", dis_ready, 1);
        tick();
        chk("rst_hold_iss_valid_1", iss_valid_1, 0);
        chk("rst_hold_free_cnt", free_cnt, 8);
        reset = 1'b1;
        #1;
        chk("rel_free_cnt", free_cnt, 8);
        tick(); clr(); #1;
        chk("rel_iss_valid_1", iss_valid_1, 1);
        chk("rel_iss_payload_1", iss_payload_1, 32'hA1);
        chk("rel_inst_issued_1", inst_issued_1, 1);
        chk("rel_bc_dst_1", bc_dst_1, 10);
        chk("rel_iss_valid_2", iss_valid_2, 0);
        chk("rel_free_cnt_busy", free_cnt, 7);

        // Back-to-back dependent pair
        tick();
        slot_rdy(1, 32'h0A, 6'd5, 1'b1);
        slot_wait(2, 32'h0B, 6'd6, 1'b1, 1, 6'd5, 4'b1111);
        #1;
        chk("idle_free_cnt", free_cnt, 8);
        chk("idle_iss_valid_1", iss_valid_1, 0);
        tick(); clr(); #1;
        chk("b2b_a_valid", iss_valid_1, 1);
        chk("b2b_a_payload", iss_payload_1, 32'h0A);
        chk("b2b_a_issued", inst_issued_1, 1);
        chk("b2b_a_bc_dst", bc_dst_1, 5);
        chk("b2b_b_not_yet", iss_valid_2, 0);
        tick(); #1;
        chk("b2b_b_valid", iss_valid_1, 1);
        chk("b2b_b_payload", iss_payload_1, 32'h0B);
        chk("b2b_b_bc_dst", bc_dst_1, 6);
        tick(); #1;
        chk("b2b_drained", iss_valid_1, 0);

        // MUL latency chain, consumer delay 1100
        slot_rdy(1, 32'h07, 6'd7, 1'b1);
        slot_wait(2, 32'h0C, 6'd12, 1'b1, 1, 6'd7, 4'b1100);
        tick(); clr(); #1;
        chk("mul_prod_payload", iss_payload_1, 32'h07);
        chk("mul_prod_bc_dst", bc_dst_1, 7);
        chk("mul_cons_not_t0", iss_valid_2, 0);
        tick(); #1;
        chk("mul_t1", iss_valid_1, 0);
        tick(); #1;
        chk("mul_t2", iss_valid_1, 0);
        tick(); #1;
        chk("mul_t3_valid", iss_valid_1, 1);
        chk("mul_t3_payload", iss_payload_1, 32'h0C);
        tick(); #1;
        chk("mul_drained", iss_valid_1, 0);

        // LD latency chain, consumer waits on src2 with delay 1000
        slot_rdy(1, 32'h08, 6'd8, 1'b1);
        slot_wait(2, 32'h0D, 6'd13, 1'b1, 2, 6'd8, 4'b1000);
        tick(); clr(); #1;
        chk("ld_prod_payload", iss_payload_1, 32'h08);
        tick(); #1;
        chk("ld_t1", iss_valid_1, 0);
        tick(); #1;
        chk("ld_t2", iss_valid_1, 0);
        tick(); #1;
        chk("ld_t3", iss_valid_1, 0);
        tick(); #1;
        chk("ld_t4_valid", iss_valid_1, 1);
        chk("ld_t4_payload", iss_payload_1, 32'h0D);
        tick(); #1;
        chk("ld_drained", iss_valid_1, 0);

        // Age order: younger entries land in lower indices once entry 0 frees
        slot_rdy(1, 32'h40, 6'd22, 1'b1);
        tick(); clr();
        slot_wait(1, 32'h41, 6'd30, 1'b0, 1, 6'd20, 4'b1111);
        slot_wait(2, 32'h42, 6'd30, 1'b0, 1, 6'd20, 4'b1111);
        #1;
        chk("age_r0_payload", iss_payload_1, 32'h40);
        tick(); clr();
        slot_wait(1, 32'h43, 6'd30, 1'b0, 1, 6'd20, 4'b1111);
        slot_wait(2, 32'h44, 6'd30, 1'b0, 2, 6'd20, 4'b1111);
        #1;
        chk("age_free_6", free_cnt, 6);
        chk("age_blocked", iss_valid_1, 0);
        tick(); clr();
        slot_wait(1, 32'h45, 6'd30, 1'b0, 1, 6'd20, 4'b1111);
        slot_wait(2, 32'h46, 6'd30, 1'b0, 1, 6'd20, 4'b1111);
        #1;
        chk("age_free_4", free_cnt, 4);
        tick(); clr();
        slot_wait(1, 32'h47, 6'd30, 1'b0, 2, 6'd20, 4'b1111);
        slot_wait(2, 32'h48, 6'd30, 1'b0, 1, 6'd20, 4'b1111);
        #1;
        chk("age_free_2", free_cnt, 2);
        chk("age_ready_at_2", dis_ready, 1);
        tick(); clr();
        ext_bc_valid_1 = 1'b1; ext_bc_dst_1 = 6'd20;
        #1;
        chk("full_dis_ready", dis_ready, 0);
        chk("full_free_cnt", free_cnt, 0);
        chk("full_iss_valid_1", iss_valid_1, 0);
        tick(); clr(); #1;
        chk("age_c6_p1", iss_payload_1, 32'h41);
        chk("age_c6_p2", iss_payload_2, 32'h42);
        chk("age_c6_v2", iss_valid_2, 1);
        chk("age_c6_no_wr", inst_issued_1, 0);
        chk("age_c6_free", free_cnt, 0);
        tick(); #1;
        chk("age_c7_p1", iss_payload_1, 32'h43);
        chk("age_c7_p2", iss_payload_2, 32'h44);
        chk("age_c7_free", free_cnt, 2);
        tick(); #1;
        chk("age_c8_p1", iss_payload_1, 32'h45);
        chk("age_c8_p2", iss_payload_2, 32'h46);
        chk("age_c8_free", free_cnt, 4);
        tick(); #1;
        chk("age_c9_p1", iss_payload_1, 32'h47);
        chk("age_c9_p2", iss_payload_2, 32'h48);
        chk("age_c9_free", free_cnt, 6);
        tick(); #1;
        chk("age_done_valid", iss_valid_1, 0);
        chk("age_done_free", free_cnt, 8);

        // Same-cycle bypass, duplicate tag on both external ports
        slot_wait(1, 32'h91, 6'd14, 1'b1, 1, 6'd9, 4'b1111);
        slot_wait(2, 32'h92, 6'd15, 1'b1, 2, 6'd9, 4'b1111);
        ext_bc_valid_1 = 1'b1; ext_bc_dst_1 = 6'd9;
        ext_bc_valid_2 = 1'b1; ext_bc_dst_2 = 6'd9;
        tick(); clr(); #1;
        chk("byp_p1_valid", iss_valid_1, 1);
        chk("byp_p1_payload", iss_payload_1, 32'h91);
        chk("byp_p2_payload", iss_payload_2, 32'h92);
        chk("byp_p2_issued", inst_issued_2, 1);
        chk("byp_p2_bc_dst", bc_dst_2, 15);
        tick(); #1;
        chk("byp_drained", iss_valid_1, 0);

        // Flush with 5 entries about to become ready and a dispatch pending
        slot_wait(1, 32'hF1, 6'd31, 1'b0, 1, 6'd25, 4'b1111);
        slot_wait(2, 32'hF2, 6'd31, 1'b0, 2, 6'd25, 4'b1111);
        tick(); clr();
        slot_wait(1, 32'hF3, 6'd31, 1'b0, 1, 6'd25, 4'b1111);
        slot_wait(2, 32'hF4, 6'd31, 1'b0, 1, 6'd25, 4'b1111);
        tick(); clr();
        slot_wait(1, 32'hF5, 6'd31, 1'b0, 2, 6'd25, 4'b1111);
        ext_bc_valid_1 = 1'b1; ext_bc_dst_1 = 6'd25;
        #1;
        chk("fl_pre_free", free_cnt, 4);
        tick(); clr();
        flush = 1'b1;
        slot_rdy(1, 32'hFF, 6'd16, 1'b1);
        #1;
        chk("fl_iss_valid_1", iss_valid_1, 0);
        chk("fl_iss_valid_2", iss_valid_2, 0);
        chk("fl_inst_issued_1", inst_issued_1, 0);
        chk("fl_iss_payload_1", iss_payload_1, 0);
        chk("fl_free_cnt", free_cnt, 3);
        tick(); clr(); #1;
        chk("fl_after_free", free_cnt, 8);
        chk("fl_after_valid", iss_valid_1, 0);
        chk("fl_after_ready", dis_ready, 1);
        tick(); #1;
        chk("fl_after2_valid", iss_valid_1, 0);
        slot_rdy(1, 32'hE1, 6'd17, 1'b1);
        tick(); clr(); #1;
        chk("post_fl_payload", iss_payload_1, 32'hE1);
        chk("post_fl_bc_dst", bc_dst_1, 17);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
